// File: rtl/wb_host_master.sv
// Wishbone classic (B3) single-transfer master.
// One command in, one bus cycle out, one response back, with an ack timeout
// and a saturating count of timed-out transfers.
module wb_host_master #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255,
  parameter int ECW     = 8
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_n_i,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic            cmd_we_i,
  input  logic [AW-1:0]   cmd_adr_i,
  input  logic [DW-1:0]   cmd_dat_i,
  input  logic [DW/8-1:0] cmd_sel_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [DW-1:0]   rsp_dat_o,
  output logic            rsp_err_o,
  output logic [ECW-1:0]  err_cnt_o,
  output logic            wbm_cyc_o,
  output logic            wbm_stb_o,
  output logic            wbm_we_o,
  output logic [DW/8-1:0] wbm_sel_o,
  output logic [AW-1:0]   wbm_adr_o,
  output logic [DW-1:0]   wbm_dat_o,
  input  logic            wbm_ack_i,
  input  logic [DW-1:0]   wbm_dat_i
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  // Counter only needs to reach TIMEOUT-1; the abort fires on that value.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t        state, state_next;
  logic [TW-1:0] tmo_cnt;
  logic          accept, ack_done, abort, rsp_done;

  function automatic logic [ECW-1:0] sat_inc(input logic [ECW-1:0] v);
    return (&v) ? v : v + ECW'(1);
  endfunction

  assign cmd_ready_o = (state == IDLE);

  // Next-state decode and per-edge event strobes.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    ack_done   = 1'b0;
    abort      = 1'b0;
    rsp_done   = 1'b0;
    case (state)
      IDLE: if (cmd_valid_i) begin
        accept     = 1'b1;
        state_next = BUS;
      end
      BUS: begin
        // Ack has priority over a coincident timeout expiry.
        if (wbm_ack_i) begin
          ack_done   = 1'b1;
          state_next = RESP;
        end else if ((TIMEOUT > 0) && (tmo_cnt == TMO_LAST)) begin
          abort      = 1'b1;
          state_next = RESP;
        end
      end
      RESP: if (rsp_ready_i) begin
        rsp_done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) state <= IDLE;
    else             state <= state_next;
  end

  // Bus-side outputs: loaded on accept, held through the cycle, dropped at its end.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
    end else if (accept) begin
      wbm_cyc_o <= 1'b1;
      wbm_stb_o <= 1'b1;
      wbm_we_o  <= cmd_we_i;
      wbm_sel_o <= cmd_sel_i;
      wbm_adr_o <= cmd_adr_i;
      wbm_dat_o <= cmd_dat_i;
    end else if (ack_done || abort) begin
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
    end
  end

  // Response channel: captured at the end of the bus cycle, held until consumed.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_dat_o   <= '0;
    end else if (ack_done) begin
      rsp_valid_o <= 1'b1;
      rsp_err_o   <= 1'b0;
      rsp_dat_o   <= wbm_we_o ? '0 : wbm_dat_i;
    end else if (abort) begin
      rsp_valid_o <= 1'b1;
      rsp_err_o   <= 1'b1;
      rsp_dat_o   <= '1;
    end else if (rsp_done) begin
      rsp_valid_o <= 1'b0;
    end
  end

  // Ack timeout counter and saturating error count.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      tmo_cnt   <= '0;
      err_cnt_o <= '0;
    end else begin
      if (accept || rsp_done)                      tmo_cnt <= '0;
      else if (state == BUS && !wbm_ack_i && !abort) tmo_cnt <= tmo_cnt + TW'(1);
      if (abort) err_cnt_o <= sat_inc(err_cnt_o);
    end
  end

endmodule
